// File: rtl/trdb_packet_serializer.sv
// rtl/trdb_packet_serializer.sv - trace packet FIFO and byte-stream serializer for the trace sink
// Packets are captured whole and emitted as one header byte then LSB-first payload bytes.
module trdb_packet_serializer #(
    parameter int PTYPE_W    = 3,
    parameter int LEN_W      = 5,
    parameter int PAYLOAD_W  = 248,
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 packet_valid_i,
    input  logic [PTYPE_W-1:0]   packet_type_i,
    input  logic [LEN_W-1:0]     packet_length_i,
    input  logic [PAYLOAD_W-1:0] packet_payload_i,
    output logic                 byte_valid_o,
    input  logic                 byte_ready_i,
    output logic [7:0]           byte_data_o,
    output logic                 byte_last_o,
    output logic                 overflow_o,
    input  logic                 overflow_clr_i,
    output logic [CNT_W-1:0]     drop_count_o
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int MAX_LEN = PAYLOAD_W / 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEADER,
        S_PAYLOAD
    } state_t;

    state_t state_q, state_d;

    logic [PTYPE_W-1:0]   type_mem [FIFO_DEPTH];
    logic [LEN_W-1:0]     len_mem  [FIFO_DEPTH];
    logic [PAYLOAD_W-1:0] pl_mem   [FIFO_DEPTH];

    logic [AW:0]          wr_ptr_q, rd_ptr_q;
    logic [AW:0]          fifo_count;
    logic                 fifo_empty, fifo_full, more_after_pop;
    logic                 pop, push_ok, drop;
    logic [LEN_W-1:0]     push_len;

    logic [LEN_W-1:0]     byte_cnt_q, byte_cnt_d;
    logic [PTYPE_W-1:0]   head_type;
    logic [LEN_W-1:0]     head_len;
    logic [PAYLOAD_W-1:0] head_payload;
    logic [PAYLOAD_W-1:0] payload_shifted;
    logic [7:0]           header_byte;
    logic                 payload_last;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign fifo_empty     = (wr_ptr_q == rd_ptr_q);
    assign fifo_full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                            (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign fifo_count     = wr_ptr_q - rd_ptr_q;
    assign more_after_pop = (fifo_count != (AW+1)'(1));

    assign push_ok = packet_valid_i && (!fifo_full || pop);
    assign drop    = packet_valid_i && !push_ok;

    // The clamp only exists when the length field can exceed the payload capacity.
    if (MAX_LEN < (1 << LEN_W) - 1) begin : g_clamp
        localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
        assign push_len = (packet_length_i > MAX_LEN_L) ? MAX_LEN_L : packet_length_i;
    end else begin : g_no_clamp
        assign push_len = packet_length_i;
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            type_mem[wr_ptr_q[AW-1:0]] <= packet_type_i;
            len_mem[wr_ptr_q[AW-1:0]]  <= push_len;
            pl_mem[wr_ptr_q[AW-1:0]]   <= packet_payload_i;
        end
    end

    assign head_type       = type_mem[rd_ptr_q[AW-1:0]];
    assign head_len        = len_mem[rd_ptr_q[AW-1:0]];
    assign head_payload    = pl_mem[rd_ptr_q[AW-1:0]];
    assign header_byte     = 8'({head_len, head_type});
    assign payload_shifted = head_payload >> {byte_cnt_q, 3'b000};
    assign payload_last    = (byte_cnt_q == head_len - LEN_W'(1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            overflow_o   <= 1'b0;
            drop_count_o <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
            // A drop coinciding with a clear restarts the count at one.
            if (drop) begin
                overflow_o <= 1'b1;
                if (overflow_clr_i) begin
                    drop_count_o <= CNT_W'(1);
                end else if (drop_count_o != '1) begin
                    drop_count_o <= drop_count_o + CNT_W'(1);
                end
            end else if (overflow_clr_i) begin
                overflow_o   <= 1'b0;
                drop_count_o <= '0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        pop          = 1'b0;
        byte_valid_o = 1'b0;
        byte_data_o  = 8'h00;
        byte_last_o  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_d = S_HEADER;
                end
            end
            S_HEADER: begin
                byte_valid_o = 1'b1;
                byte_data_o  = header_byte;
                byte_last_o  = (head_len == '0);
                if (byte_ready_i) begin
                    if (head_len == '0) begin
                        pop     = 1'b1;
                        state_d = more_after_pop ? S_HEADER : S_IDLE;
                    end else begin
                        byte_cnt_d = '0;
                        state_d    = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                byte_valid_o = 1'b1;
                byte_data_o  = payload_shifted[7:0];
                byte_last_o  = payload_last;
                if (byte_ready_i) begin
                    if (payload_last) begin
                        pop     = 1'b1;
                        state_d = more_after_pop ? S_HEADER : S_IDLE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + LEN_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_trdb_packet_serializer.sv
// tb/tb_trdb_packet_serializer.sv - self-checking bench for trdb_packet_serializer
module tb_trdb_packet_serializer;

    localparam int PTYPE_W    = 3;
    localparam int LEN_W      = 5;
    localparam int PAYLOAD_W  = 248;
    localparam int FIFO_DEPTH = 2;
    localparam int CNT_W      = 16;

    logic                 clk = 1'b0;
    logic                 rst_i;
    logic                 packet_valid_i;
    logic [PTYPE_W-1:0]   packet_type_i;
    logic [LEN_W-1:0]     packet_length_i;
    logic [PAYLOAD_W-1:0] packet_payload_i;
    logic                 byte_valid_o;
    logic                 byte_ready_i;
    logic [7:0]           byte_data_o;
    logic                 byte_last_o;
    logic                 overflow_o;
    logic                 overflow_clr_i;
    logic [CNT_W-1:0]     drop_count_o;

    int n_tests = 0;
    int n_fail  = 0;

    trdb_packet_serializer #(
        .PTYPE_W(PTYPE_W), .LEN_W(LEN_W), .PAYLOAD_W(PAYLOAD_W),
        .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .packet_valid_i(packet_valid_i), .packet_type_i(packet_type_i),
        .packet_length_i(packet_length_i), .packet_payload_i(packet_payload_i),
        .byte_valid_o(byte_valid_o), .byte_ready_i(byte_ready_i),
        .byte_data_o(byte_data_o), .byte_last_o(byte_last_o),
        .overflow_o(overflow_o), .overflow_clr_i(overflow_clr_i),
        .drop_count_o(drop_count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] t;
        logic [4:0] len;
        logic [7:0] seed;
        logic [7:0] exp_hdr;
    } vec_t;

    typedef struct {
        logic [2:0]           t;
        int                   len;
        logic [PAYLOAD_W-1:0] pl;
    } pkt_t;

    pkt_t mq[$];
    bit   m_active;
    int   m_idx;
    bit   m_ovf;
    int   m_drop;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PAYLOAD_W-1:0] mkpl(input logic [7:0] seed);
        logic [PAYLOAD_W-1:0] p;
        p = '0;
        for (int k = 0; k < PAYLOAD_W / 8; k++) p[8*k +: 8] = seed ^ 8'(k * 17);
        return p;
    endfunction

    task automatic push(input logic [2:0] t, input logic [4:0] len, input logic [PAYLOAD_W-1:0] pl);
        packet_valid_i   = 1'b1;
        packet_type_i    = t;
        packet_length_i  = len;
        packet_payload_i = pl;
        tick();
        packet_valid_i   = 1'b0;
    endtask

    task automatic expect_byte(input string name, input logic [7:0] d, input logic l);
        check($sformatf("%s valid", name), byte_valid_o, 1);
        check($sformatf("%s data", name), byte_data_o, d);
        check($sformatf("%s last", name), byte_last_o, l);
        tick();
    endtask

    function automatic logic [7:0] mbyte(input pkt_t p, input int idx);
        logic [4:0] l5;
        l5 = p.len[4:0];
        if (idx == 0) return {l5, p.t};
        return p.pl[8*(idx-1) +: 8];
    endfunction

    // Reference: packets queue up to FIFO_DEPTH; a new packet shows one cycle after it
    // becomes visible, and the next queued packet follows immediately after a last byte.
    task automatic model_step(input bit pv, input pkt_t np, input bit rdy, input bit clr);
        bit last, pop, pok;
        int sz;
        sz   = mq.size();
        last = m_active && (m_idx == mq[0].len);
        pop  = m_active && rdy && last;
        pok  = pv && (sz < FIFO_DEPTH || pop);
        if (m_active) begin
            if (rdy) begin
                if (pop) begin
                    m_active = (sz - 1) > 0;
                    m_idx = 0;
                end else m_idx++;
            end
        end else m_active = sz > 0;
        if (pop) void'(mq.pop_front());
        if (pok) mq.push_back(np);
        if (pv && !pok) begin
            m_ovf = 1;
            if (clr) m_drop = 1;
            else if (m_drop < 65535) m_drop++;
        end else if (clr) begin
            m_ovf = 0;
            m_drop = 0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        logic [PAYLOAD_W-1:0] pl;
        logic [7:0] prev_d;
        bit   prev_stall;
        int   idx, cyc;

        vecs[0] = '{3'b010, 5'd2,  8'hAA, 8'h12};
        vecs[1] = '{3'b101, 5'd0,  8'h00, 8'h05};
        vecs[2] = '{3'b000, 5'd1,  8'h5C, 8'h08};
        vecs[3] = '{3'b111, 5'd31, 8'h3C, 8'hFF};
        vecs[4] = '{3'b011, 5'd7,  8'hC1, 8'h3B};

        rst_i = 1'b1; packet_valid_i = 0; packet_type_i = 0; packet_length_i = 0;
        packet_payload_i = '0; byte_ready_i = 0; overflow_clr_i = 0;
        #3;
        check("reset valid", byte_valid_o, 0);
        check("reset data", byte_data_o, 0);
        check("reset last", byte_last_o, 0);
        check("reset overflow", overflow_o, 0);
        check("reset drop_count", drop_count_o, 0);
        tick(); tick();
        rst_i = 1'b0;
        tick();

        byte_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push(vecs[i].t, vecs[i].len, mkpl(vecs[i].seed));
            check($sformatf("vec%0d latency", i), byte_valid_o, 0);
            tick();
            expect_byte($sformatf("vec%0d hdr", i), vecs[i].exp_hdr, vecs[i].len == 0);
            for (int k = 0; k < int'(vecs[i].len); k++)
                expect_byte($sformatf("vec%0d b%0d", i, k), vecs[i].seed ^ 8'(k * 17),
                            k == int'(vecs[i].len) - 1);
            check($sformatf("vec%0d idle", i), byte_valid_o, 0);
        end

        push(3'd1, 5'd1, mkpl(8'h11));
        push(3'd6, 5'd1, mkpl(8'h22));
        expect_byte("b2b hdrA", 8'h09, 0);
        expect_byte("b2b A0", 8'h11, 1);
        expect_byte("b2b hdrB", 8'h0E, 0);
        expect_byte("b2b B0", 8'h22, 1);
        check("b2b idle", byte_valid_o, 0);

        byte_ready_i = 1'b0;
        push(3'd1, 5'd1, mkpl(8'h31));
        push(3'd2, 5'd1, mkpl(8'h32));
        push(3'd3, 5'd1, mkpl(8'h33));
        check("ovf flag", overflow_o, 1);
        check("ovf count", drop_count_o, 1);
        check("ovf head held", byte_data_o, 8'h09);
        overflow_clr_i = 1'b1;
        tick();
        overflow_clr_i = 1'b0;
        check("clr flag", overflow_o, 0);
        check("clr count", drop_count_o, 0);
        byte_ready_i = 1'b1;
        tick();
        byte_ready_i = 1'b0;
        check("stall data", byte_data_o, 8'h31);
        tick();
        check("stall valid", byte_valid_o, 1);
        check("stall data held", byte_data_o, 8'h31);
        check("stall last held", byte_last_o, 1);
        byte_ready_i = 1'b1;
        push(3'd4, 5'd1, mkpl(8'h34));
        check("full+pop count", drop_count_o, 0);
        check("full+pop flag", overflow_o, 0);
        expect_byte("full hdrP2", 8'h0A, 0);
        expect_byte("full P2", 8'h32, 1);
        expect_byte("full hdrP4", 8'h0C, 0);
        expect_byte("full P4", 8'h34, 1);
        check("full idle", byte_valid_o, 0);

        push(3'd5, 5'd5, mkpl(8'h40));
        tick();
        tick();
        byte_ready_i = 1'b0; tick();
        byte_ready_i = 1'b1; tick();
        check("pre-rst valid", byte_valid_o, 1);
        rst_i = 1'b1;
        #1;
        check("async rst valid", byte_valid_o, 0);
        check("async rst data", byte_data_o, 0);
        check("async rst last", byte_last_o, 0);
        tick(); tick();
        rst_i = 1'b0;
        tick();
        check("post-rst idle0", byte_valid_o, 0);
        tick();
        check("post-rst idle1", byte_valid_o, 0);
        push(3'd0, 5'd1, mkpl(8'h7E));
        check("post-rst latency", byte_valid_o, 0);
        tick();
        expect_byte("post-rst hdr", 8'h08, 0);
        expect_byte("post-rst b0", 8'h7E, 1);
        check("post-rst idle2", byte_valid_o, 0);

        pl = '0;
        for (int k = 0; k < 31; k++) pl[8*k +: 8] = 8'(k);
        push(3'd0, 5'd31, pl);
        idx = 0; cyc = 0; prev_stall = 0; prev_d = 0;
        while (idx < 32 && cyc < 500) begin
            if (prev_stall) begin
                check("len31 valid held", byte_valid_o, 1);
                check("len31 data held", byte_data_o, prev_d);
            end
            if (byte_valid_o) begin
                check($sformatf("len31 data%0d", idx), byte_data_o, (idx == 0) ? 8'hF8 : 8'(idx - 1));
                check($sformatf("len31 last%0d", idx), byte_last_o, idx == 31);
            end
            byte_ready_i = 1'($urandom_range(0, 1));
            prev_stall = byte_valid_o && !byte_ready_i;
            prev_d = byte_data_o;
            if (byte_valid_o && byte_ready_i) idx++;
            tick();
            cyc++;
        end
        check("len31 byte count", idx, 32);
        check("len31 idle", byte_valid_o, 0);

        rst_i = 1'b1; tick(); rst_i = 1'b0; tick();
        mq.delete(); m_active = 0; m_idx = 0; m_ovf = 0; m_drop = 0;
        for (int c = 0; c < 2000; c++) begin
            pkt_t np;
            logic [255:0] wide;
            bit pv, rdy, clr;
            int raw;
            check("rnd valid", byte_valid_o, m_active);
            if (m_active) begin
                check("rnd data", byte_data_o, mbyte(mq[0], m_idx));
                check("rnd last", byte_last_o, m_idx == mq[0].len);
            end
            check("rnd overflow", overflow_o, m_ovf);
            check("rnd drop_count", drop_count_o, m_drop);
            for (int w = 0; w < 8; w++) wide[32*w +: 32] = $urandom();
            raw   = ($urandom_range(0, 7) == 0) ? 31 : $urandom_range(0, 4);
            np.t  = 3'($urandom());
            np.len = (raw > 31) ? 31 : raw;
            np.pl = wide[PAYLOAD_W-1:0];
            pv    = ($urandom_range(0, 9) < 4);
            rdy   = ($urandom_range(0, 9) < 7);
            clr   = ($urandom_range(0, 29) == 0);
            packet_valid_i   = pv;
            packet_type_i    = np.t;
            packet_length_i  = 5'(raw);
            packet_payload_i = np.pl;
            byte_ready_i     = rdy;
            overflow_clr_i   = clr;
            model_step(pv, np, rdy, clr);
            tick();
        end
        packet_valid_i = 0;
        overflow_clr_i = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
